// File: rtl/mdu_scheduler_pkg.sv
// Shared definitions for the MDU scheduler: RV32M funct3 encodings and the FSM state type.
package mdu_scheduler_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mdu_sched_state;

endpackage

// File: rtl/mdu_scheduler_fastpath.sv
// Combinational RV32M corner-case detector: divide by zero and signed divide overflow
// resolve locally without starting the shared core.
module mdu_fastpath
    import mdu_scheduler_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic              hit,
    output logic [DATA_W-1:0] result
);

    localparam logic signed [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // INT_MIN / -1 is the only signed quotient that does not fit; it saturates to INT_MIN.
    function automatic logic div_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
        return (a == INT_MIN) && (b == '1);
    endfunction

    logic div_zero;
    logic ovf;

    always_comb begin
        hit      = 1'b0;
        result   = '0;
        div_zero = (op2 == '0);
        ovf      = div_ovf(op1, op2);
        case (func)
            MDU_DIV: begin
                if (div_zero) begin
                    hit    = 1'b1;
                    result = '1;
                end else if (ovf) begin
                    hit    = 1'b1;
                    result = op1;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    hit    = 1'b1;
                    result = '1;
                end
            end
            MDU_REM: begin
                if (div_zero) begin
                    hit    = 1'b1;
                    result = op1;
                end else if (ovf) begin
                    hit    = 1'b1;
                    result = '0;
                end
            end
            MDU_REMU: begin
                if (div_zero) begin
                    hit    = 1'b1;
                    result = op1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_scheduler.sv
// Shares one iterative MDU core between two execute lanes: round-robin grant, operand
// capture, start/kill sequencing, local fast path, completion watchdog and result hold.
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int DATA_W  = 32
) (
    input  logic              s_clk_i,
    input  logic              s_reset_i,
    input  logic [1:0]        s_req_i,
    input  logic [2:0]        s_func_i [2],
    input  logic [DATA_W-1:0] s_op1_i  [2],
    input  logic [DATA_W-1:0] s_op2_i  [2],
    input  logic [1:0]        s_flush_i,
    input  logic [1:0]        s_rdy_i,
    output logic [1:0]        s_gnt_o,
    output logic [1:0]        s_valid_o,
    output logic              s_err_o,
    output logic [DATA_W-1:0] s_result_o,
    output logic              s_mdu_start_o,
    output logic              s_mdu_kill_o,
    output logic [2:0]        s_mdu_func_o,
    output logic [DATA_W-1:0] s_mdu_op1_o,
    output logic [DATA_W-1:0] s_mdu_op2_o,
    input  logic              s_mdu_done_i,
    input  logic [DATA_W-1:0] s_mdu_result_i
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mdu_sched_state    state;
    logic              owner;
    logic              last_served;
    logic [WD_W-1:0]   wd_cnt;
    logic [1:0]        elig;
    logic              sel;
    logic              fp_hit;
    logic [DATA_W-1:0] fp_result;

    // A flushed lane is not eligible; on a tie the lane not served last wins.
    always_comb begin
        elig    = s_req_i & ~s_flush_i;
        sel     = 1'b0;
        s_gnt_o = 2'b00;
        if (state == IDLE && elig != 2'b00) begin
            sel     = (elig == 2'b11) ? ~last_served : elig[1];
            s_gnt_o = sel ? 2'b10 : 2'b01;
        end
    end

    mdu_fastpath #(
        .DATA_W (DATA_W)
    ) u_fastpath (
        .func   (s_func_i[sel]),
        .op1    (s_op1_i[sel]),
        .op2    (s_op2_i[sel]),
        .hit    (fp_hit),
        .result (fp_result)
    );

    assign s_valid_o = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_served   <= 1'b1;
            wd_cnt        <= '0;
            s_mdu_start_o <= 1'b0;
            s_mdu_kill_o  <= 1'b0;
            s_mdu_func_o  <= '0;
            s_mdu_op1_o   <= '0;
            s_mdu_op2_o   <= '0;
            s_result_o    <= '0;
            s_err_o       <= 1'b0;
        end else begin
            s_mdu_start_o <= 1'b0;
            s_mdu_kill_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_gnt_o != 2'b00) begin
                        owner        <= sel;
                        last_served  <= sel;
                        s_mdu_func_o <= s_func_i[sel];
                        s_mdu_op1_o  <= s_op1_i[sel];
                        s_mdu_op2_o  <= s_op2_i[sel];
                        if (fp_hit) begin
                            s_result_o <= fp_result;
                            s_err_o    <= 1'b0;
                            state      <= RESP;
                        end else begin
                            wd_cnt        <= '0;
                            s_mdu_start_o <= 1'b1;
                            state         <= BUSY;
                        end
                    end
                end
                // Priority: owner flush, then core done, then watchdog expiry.
                BUSY: begin
                    if (s_flush_i[owner]) begin
                        s_mdu_kill_o <= 1'b1;
                        state        <= IDLE;
                    end else if (s_mdu_done_i) begin
                        s_result_o <= s_mdu_result_i;
                        s_err_o    <= 1'b0;
                        state      <= RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        s_mdu_kill_o <= 1'b1;
                        s_result_o   <= '0;
                        s_err_o      <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (s_rdy_i[owner] || s_flush_i[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Scoreboard bench for mdu_scheduler with a behavioural MDU core and an RV32M reference model.
module tb_mdu_scheduler;
    import mdu_scheduler_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  flush = 2'b00;
    logic [1:0]  rdy = 2'b11;
    logic [2:0]  func [2];
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic [1:0]  gnt, valid;
    logic        err;
    logic [31:0] result;
    logic        mdu_start, mdu_kill;
    logic [2:0]  mdu_func;
    logic [31:0] mdu_op1, mdu_op2;
    logic        mdu_done;
    logic [31:0] mdu_res;
    logic        inj_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_cyc [2];
    int valid_cyc [2];
    bit vhold [2];
    int start_cnt = 0, start_cyc = 0, kill_cnt = 0, kill_cyc = 0;
    logic ls_model = 1'b1;
    logic [1:0] gnt_last = 2'b00;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_scheduler dut (
        .s_clk_i        (clk),
        .s_reset_i      (rst),
        .s_req_i        (req),
        .s_func_i       (func),
        .s_op1_i        (op1),
        .s_op2_i        (op2),
        .s_flush_i      (flush),
        .s_rdy_i        (rdy),
        .s_gnt_o        (gnt),
        .s_valid_o      (valid),
        .s_err_o        (err),
        .s_result_o     (result),
        .s_mdu_start_o  (mdu_start),
        .s_mdu_kill_o   (mdu_kill),
        .s_mdu_func_o   (mdu_func),
        .s_mdu_op1_o    (mdu_op1),
        .s_mdu_op2_o    (mdu_op2),
        .s_mdu_done_i   (mdu_done),
        .s_mdu_result_i (mdu_res)
    );

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] rv32m(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p = '0;
        r = '0;
        case (f)
            MDU_MUL:    begin p = ua * ub; r = p[31:0];  end
            MDU_MULH:   begin p = sa * sb; r = p[63:32]; end
            MDU_MULHSU: begin p = sa * ub; r = p[63:32]; end
            MDU_MULHU:  begin p = ua * ub; r = p[63:32]; end
            MDU_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            MDU_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM:    r = (b == 0) ? a : 32'(sa % sb);
            default:    r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Behavioural core: done appears core_lat cycles after the start cycle; 0 = never.
    int          core_lat = 2;
    logic        core_busy;
    int          core_cnt;
    logic        core_done;
    logic [31:0] core_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_done <= 1'b0;
            core_res  <= '0;
        end else begin
            core_done <= 1'b0;
            if (mdu_kill) begin
                core_busy <= 1'b0;
            end else if (mdu_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 1;
                core_res  <= rv32m(mdu_func, mdu_op1, mdu_op2);
            end else if (core_busy && core_lat != 0) begin
                if (core_cnt >= core_lat - 1) begin
                    core_done <= 1'b1;
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end

    assign mdu_done = core_done | inj_done;
    assign mdu_res  = core_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req = req & ~gnt_last;
    endtask

    task automatic issue(input int lane, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit exp_err);
        exp_t e;
        func[lane] = f;
        op1[lane]  = a;
        op2[lane]  = b;
        req[lane]  = 1'b1;
        e.res = exp_err ? 32'h0 : rv32m(f, a, b);
        e.err = exp_err;
        if (lane == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic drain(input string name, input int budget, input bit rand_rdy);
        int n = 0;
        while ((req != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
            if (rand_rdy) rdy = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        rdy = 2'b11;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s drain: no completion within %0d cycles (req=%b q0=%0d q1=%0d)",
                     name, budget, req, exp_q0.size(), exp_q1.size());
            req = 2'b00;
            exp_q0.delete();
            exp_q1.delete();
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: arbitration model and result scoreboard, sampled on the falling edge.
    initial begin
        logic [1:0] elig;
        logic       el;
        int         lane;
        bit         have;
        exp_t       e;
        forever begin
            @(negedge clk);
            gnt_last = rst ? 2'b00 : gnt;
            if (!rst) begin
                if (gnt != 2'b00) begin
                    elig = req & ~flush;
                    el = (elig == 2'b11) ? ~ls_model : elig[1];
                    checks++;
                    if (elig == 2'b00 || gnt != (el ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL arb: gnt=%b expected lane %0d (req=%b flush=%b)",
                                 gnt, el, req, flush);
                    end
                    ls_model = el;
                    gnt_cyc[el] = cyc;
                end
                if (mdu_start) begin start_cnt++; start_cyc = cyc; end
                if (mdu_kill) begin kill_cnt++; kill_cyc = cyc; end
                if (valid != 2'b00) begin
                    lane = valid[1] ? 1 : 0;
                    have = (lane == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    checks++;
                    if (valid == 2'b11) begin
                        errors++;
                        $display("FAIL valid_onehot: got %b expected one-hot", valid);
                    end else if (!have) begin
                        errors++;
                        $display("FAIL unexpected_valid: lane %0d result %0h, no response expected",
                                 lane, result);
                    end else begin
                        e = (lane == 0) ? exp_q0[0] : exp_q1[0];
                        if (result !== e.res || err !== e.err) begin
                            errors++;
                            $display("FAIL result lane%0d: got %0h err %b expected %0h err %b",
                                     lane, result, err, e.res, e.err);
                        end
                    end
                    if (!vhold[lane]) begin
                        valid_cyc[lane] = cyc;
                        vhold[lane] = 1'b1;
                    end
                    if (rdy[lane] || flush[lane]) begin
                        vhold[lane] = 1'b0;
                        if (have) begin
                            if (lane == 0) void'(exp_q0.pop_front());
                            else void'(exp_q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t0, s0, k0, n;
        logic [31:0] held;
        logic [2:0] fp_f [4];
        logic [31:0] fp_a [4];
        logic [31:0] fp_b [4];
        for (int i = 0; i < 2; i++) begin
            func[i] = '0; op1[i] = '0; op2[i] = '0;
            gnt_cyc[i] = -1; valid_cyc[i] = -1; vhold[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_start", mdu_start, 0);
        chk("rst_kill", mdu_kill, 0);
        chk("rst_func", mdu_func, 0);
        chk("rst_op1", mdu_op1, 0);
        chk("rst_op2", mdu_op2, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Tie after reset: lane 0 first, lane 1 right after lane 0's response, then lane 0 again.
        core_lat = 2;
        issue(0, MDU_MUL, 32'd3, 32'd4, 0);
        issue(1, MDU_MULH, 32'hFFFF_FFFE, 32'd5, 0);
        t0 = cyc;
        drain("tie1", 40, 0);
        chk("tie1_lane0_first", gnt_cyc[0], t0);
        chk("tie1_lane1_next", gnt_cyc[1], valid_cyc[0] + 1);
        issue(0, MDU_MULHSU, 32'h8000_0001, 32'hFFFF_FFFF, 0);
        issue(1, MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        t0 = cyc;
        drain("tie2", 40, 0);
        chk("tie2_lane0_again", gnt_cyc[0], t0);

        // Core path latency: MUL 7x6 with N=3.
        core_lat = 3;
        s0 = start_cnt;
        issue(0, MDU_MUL, 32'd7, 32'd6, 0);
        t0 = cyc;
        drain("mul", 30, 0);
        chk("mul_gnt_cyc", gnt_cyc[0], t0);
        chk("mul_start_cyc", start_cyc, t0 + 1);
        chk("mul_valid_cyc", valid_cyc[0], t0 + 5);
        chk("mul_start_cnt", start_cnt, s0 + 1);

        // Fast path: no core start, response one cycle after grant.
        fp_f[0] = MDU_DIVU; fp_a[0] = 32'd5;        fp_b[0] = 32'd0;
        fp_f[1] = MDU_DIV;  fp_a[1] = 32'h8000_0000; fp_b[1] = 32'hFFFF_FFFF;
        fp_f[2] = MDU_REM;  fp_a[2] = 32'd9;        fp_b[2] = 32'd0;
        fp_f[3] = MDU_REM;  fp_a[3] = 32'h8000_0000; fp_b[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            s0 = start_cnt;
            issue(i == 0 ? 1 : i % 2, fp_f[i], fp_a[i], fp_b[i], 0);
            t0 = cyc;
            drain("fast", 20, 0);
            chk("fast_valid_cyc", valid_cyc[i == 0 ? 1 : i % 2], t0 + 1);
            chk("fast_no_start", start_cnt, s0);
        end

        // Stalled response holds; a waiting lane is not granted until release.
        core_lat = 2;
        rdy = 2'b10;
        issue(0, MDU_MUL, 32'd123, 32'd456, 0);
        n = 0;
        do begin tick(); n++; @(negedge clk); end while (!valid[0] && n < 20);
        chk("stall_reach_resp", valid, 2'b01);
        held = result;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) issue(1, MDU_DIVU, 32'd100, 32'd7, 0);
            @(negedge clk);
            chk("stall_valid", valid, 2'b01);
            chk("stall_no_gnt", gnt, 2'b00);
            chk("stall_hold", result, held);
        end
        tick();
        rdy = 2'b11;
        t0 = cyc;
        drain("stall", 30, 0);
        chk("stall_release_gnt", gnt_cyc[1], t0 + 1);

        // Owner flush in the second BUSY cycle, then a stray late done.
        core_lat = 10;
        k0 = kill_cnt;
        issue(0, MDU_MUL, 32'd3, 32'd5, 0);
        t0 = cyc;
        tick();
        tick();
        flush = 2'b01;
        void'(exp_q0.pop_front());
        tick();
        flush = 2'b00;
        repeat (2) tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        @(negedge clk);
        chk("late_done_no_valid", valid, 2'b00);
        tick();
        chk("flush_kill_cyc", kill_cyc, t0 + 3);
        chk("flush_kill_cnt", kill_cnt, k0 + 1);

        // Flush in the same cycle as done.
        core_lat = 3;
        issue(0, MDU_DIVU, 32'd50, 32'd3, 0);
        t0 = cyc;
        repeat (4) tick();
        flush = 2'b01;
        void'(exp_q0.pop_front());
        tick();
        flush = 2'b00;
        @(negedge clk);
        chk("flush_done_no_valid", valid, 2'b00);
        tick();
        @(negedge clk);
        chk("flush_done_no_valid2", valid, 2'b00);
        chk("flush_done_kill_cyc", kill_cyc, t0 + 5);
        tick();

        // Watchdog: core never completes, then done on the last allowed cycle.
        core_lat = 0;
        k0 = kill_cnt;
        issue(0, MDU_MUL, 32'd11, 32'd13, 1);
        t0 = cyc;
        drain("timeout", 100, 0);
        chk("timeout_kill_cyc", kill_cyc, t0 + 41);
        chk("timeout_valid_cyc", valid_cyc[0], t0 + 41);
        chk("timeout_kill_cnt", kill_cnt, k0 + 1);
        core_lat = 39;
        issue(0, MDU_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        t0 = cyc;
        drain("done_at_40", 100, 0);
        chk("done40_valid_cyc", valid_cyc[0], t0 + 41);
        chk("done40_no_kill", kill_cnt, k0 + 1);

        // Randomized traffic with random stalls.
        for (int it = 0; it < 80; it++) begin
            logic [1:0] mask;
            core_lat = $urandom_range(2, 6);
            mask = 2'($urandom_range(1, 3));
            for (int l = 0; l < 2; l++)
                if (mask[l]) issue(l, 3'($urandom_range(0, 7)), rand_op(), rand_op(), 0);
            drain("random", 200, 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
